// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM encoding and LFSR mode constants for the LFSR generator
package lfsr_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;
   localparam bit FIBONACCI = 1'b0;
   localparam bit GALOIS = 1'b1;
endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control, seed-load and status signals of the LFSR generator
interface lfsr_gen_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic en;
   logic load_valid;
   logic [WIDTH-1:0] load_seed;
   logic load_ready;
   logic run_start;
   logic [CNT_W-1:0] run_count;
   logic run_busy;
   logic run_done;
   logic [WIDTH-1:0] state_q;
   logic bit_out;
   logic lockup;
   modport master (
      output en, load_valid, load_seed, run_start, run_count,
      input load_ready, run_busy, run_done, state_q, bit_out, lockup
   );
   modport slave (
      input en, load_valid, load_seed, run_start, run_count,
      output load_ready, run_busy, run_done, state_q, bit_out, lockup
   );
endinterface

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Fibonacci or Galois LFSR step
module lfsr_step import lfsr_pkg::*; #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS = 8'hB8,
   parameter bit GALOIS = FIBONACCI
) (
   input logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);
   assign nxt = GALOIS ? ({cur[WIDTH-2:0], 1'b0} ^ ({WIDTH{cur[WIDTH-1]}} & TAPS))
                       : {cur[WIDTH-2:0], ^(cur & TAPS)};
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: multi-step LFSR with seed load, free-run/counted bursts and zero-lockup recovery
module lfsr_gen import lfsr_pkg::*; #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS = 8'hB8,
   parameter logic [WIDTH-1:0] SEED = 8'h01,
   parameter bit GALOIS = FIBONACCI,
   parameter int STEPS_PER_CYCLE = 1,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst,
   lfsr_gen_if.slave bus
);
   fsm_e fsm, fsm_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] state_nxt, stepped;
   logic adv, lock;
   for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g
      logic [WIDTH-1:0] cur, nxt;
      if (i == 0) begin : g_first
         assign cur = bus.state_q;
      end else begin : g_next
         assign cur = g[i-1].nxt;
      end
      lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .GALOIS(GALOIS)) u_step (.cur(cur), .nxt(nxt));
   end
   assign stepped = g[STEPS_PER_CYCLE-1].nxt;
   assign bus.bit_out = bus.state_q[WIDTH-1];
   // next FSM state, burst count and LFSR state; a zero state reloads SEED instead of stepping
   always_comb begin
      fsm_nxt = fsm;
      cnt_nxt = cnt;
      adv = 1'b0;
      state_nxt = bus.state_q;
      case (fsm)
         IDLE: begin
            if (bus.load_valid) state_nxt = (bus.load_seed == '0) ? SEED : bus.load_seed;
            else if (bus.run_start) begin
               fsm_nxt = (bus.run_count == '0) ? DONE : RUN;
               cnt_nxt = bus.run_count;
            end else adv = bus.en;
         end
         RUN: begin
            adv = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
            fsm_nxt = (cnt == CNT_W'(1)) ? DONE : RUN;
         end
         default: fsm_nxt = IDLE;
      endcase
      lock = adv && (bus.state_q == '0);
      if (adv) state_nxt = lock ? SEED : stepped;
   end
   // register state and all status outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm <= IDLE;
         cnt <= '0;
         bus.state_q <= SEED;
         bus.lockup <= 1'b0;
         bus.load_ready <= 1'b1;
         bus.run_busy <= 1'b0;
         bus.run_done <= 1'b0;
      end else begin
         fsm <= fsm_nxt;
         cnt <= cnt_nxt;
         bus.state_q <= state_nxt;
         bus.lockup <= lock;
         bus.load_ready <= fsm_nxt == IDLE;
         bus.run_busy <= fsm_nxt == RUN;
         bus.run_done <= fsm_nxt == DONE;
      end
   end
endmodule
